alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Shares the single RISC-V ALU between two requesters, e.g. the execute stage (req0) and an address-generation/branch unit (req1). Grants one request at a time round-robin, drives the registered operands onto the ALU, and waits the ALU latency. It then returns the captured result through a valid/ready response port tagged with the requester id. Sits between the requesters and the alu module; the ALU port names and opcodes are unchanged.

Parameters:
DATA_W, 32, operand/result width
ALU_LAT, 1, cycles from ALU inputs stable to alu_result valid (0 = combinational ALU)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
reqN_valid  in  1  request N (N=0,1) valid
reqN_ready  out  1  request N accepted this cycle (valid&ready)
reqN_opr1  in  DATA_W  operand 1 (rdatain1)
reqN_opr2  in  DATA_W  operand 2 (rdatain2)
reqN_imm  in  DATA_W  immediate (dataimmed)
reqN_selopr2  in  1  1 = use immediate as operand 2
reqN_aluoper  in  4  ALU opcode (0000 ADD … 1001 SLTU)
alu_rdatain1, alu_rdatain2, alu_dataimmed  out  DATA_W each  registered drive to ALU
alu_selopr2  out  1  registered drive to ALU
alu_aluoper  out  4  registered drive to ALU
alu_result  in  DATA_W  ALU result
alu_zero  in  1  ALU zero flag
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester index of response
rsp_result  out  DATA_W  captured result
rsp_zero  out  1  captured zero flag

Behaviour:
- Reset (async, any state): state=IDLE, cnt=0, last_grant=1 (req0 wins the first tie). All outputs 0: reqN_ready, alu_* drives, rsp_*. Any in-flight operation is discarded and produces no response.
- FSM states: IDLE, BUSY, RESP.
- IDLE arbitration:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the index != last_grant.
  - reqN_ready = (state==IDLE) & grant==N. This is combinational, at most one high, and never high outside IDLE.
- IDLE on accept:
  - Register the granted operands/selopr2/aluoper into the alu_* drive registers.
  - Set rsp_id=N, last_grant=N, cnt=ALU_LAT, go BUSY.
  - With no valid, stay IDLE; last_grant and alu_* are unchanged.
- BUSY:
  - alu_* held stable.
  - If cnt!=0, decrement.
  - If cnt==0, capture alu_result→rsp_result and alu_zero→rsp_zero, then go RESP.
- RESP: rsp_valid=1. rsp_id/result/zero are held stable until rsp_ready. On rsp_valid&rsp_ready go IDLE. No request is accepted in the same cycle.
- Latency: accept in cycle T gives rsp_valid first high in cycle T+ALU_LAT+2. Minimum issue interval is ALU_LAT+3 cycles.
- Requester rule: valid plus payload held until ready. Dropping valid before ready causes no accept and no state change. The payload is sampled only in the accept cycle, so changes after accept have no effect.
- last_grant updates only on accept, not on response.
- Width: results pass through unmodified; the block performs no arithmetic.
- rsp_ready high while not in RESP is ignored.

Test Plan:
1. ALU_LAT=1. After reset, req0 ADD with opr1=0x10, opr2=0x20, selopr2=0, aluoper=0000, rsp_ready=1. Required: req0_ready high in T; rsp_valid in T+3 with rsp_result=0x00000030, rsp_zero=0, rsp_id=0; back to IDLE at T+4.
2. Both valid in the same cycle after reset: req0 SUB 0x10-0x10, req1 OR 0x10|0x20. Required: first response id=0, result=0, zero=1; second response id=1, result=0x30, zero=0.
3. Both valid continuously for 3 ops each. Required: grant/rsp_id sequence is 0,1,0,1,0,1 and never two consecutive grants to the same requester.
4. rsp_ready held low for 5 cycles in RESP. Required: rsp_valid/result/id stay stable; req0_ready and req1_ready stay 0 despite pending valids. Raise rsp_ready: IDLE the next cycle, and the next accept follows immediately.
5. req1 SLL with selopr2=1, opr1=0x10, imm=0x2, aluoper=0101. Required: alu_dataimmed=0x2 and alu_selopr2=1 through BUSY; rsp_result=0x00000040, rsp_id=1. Then SRA with opr1=0xF0000010: rsp_result=0xFC000004.
6. Assert reset one cycle into BUSY. Required: all outputs 0 immediately, with no clock edge needed, and no rsp_valid ever for that op. After release, req1 alone is granted normally and gets the correct result.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; registers the
// granted operands onto the ALU, waits ALU_LAT cycles, returns a tagged result.
module alu_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ALU_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,

   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_opr1,
   input  logic [DATA_W-1:0] req0_opr2,
   input  logic [DATA_W-1:0] req0_imm,
   input  logic              req0_selopr2,
   input  logic [3:0]        req0_aluoper,

   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_opr1,
   input  logic [DATA_W-1:0] req1_opr2,
   input  logic [DATA_W-1:0] req1_imm,
   input  logic              req1_selopr2,
   input  logic [3:0]        req1_aluoper,

   output logic [DATA_W-1:0] alu_rdatain1,
   output logic [DATA_W-1:0] alu_rdatain2,
   output logic [DATA_W-1:0] alu_dataimmed,
   output logic              alu_selopr2,
   output logic [3:0]        alu_aluoper,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_id,
   output logic [DATA_W-1:0] rsp_result,
   output logic              rsp_zero
);

   localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ALU_LAT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              r_last_grant;
   logic              w_last_grant_next;

   logic [DATA_W-1:0] r_alu_opr1, w_alu_opr1_next;
   logic [DATA_W-1:0] r_alu_opr2, w_alu_opr2_next;
   logic [DATA_W-1:0] r_alu_imm,  w_alu_imm_next;
   logic              r_alu_sel,  w_alu_sel_next;
   logic [3:0]        r_alu_op,   w_alu_op_next;

   logic              r_rsp_id,     w_rsp_id_next;
   logic [DATA_W-1:0] r_rsp_result, w_rsp_result_next;
   logic              r_rsp_zero,   w_rsp_zero_next;

   // Requester payloads gathered into arrays so the grant can index them
   logic              w_valid [2];
   logic [DATA_W-1:0] w_opr1  [2];
   logic [DATA_W-1:0] w_opr2  [2];
   logic [DATA_W-1:0] w_imm   [2];
   logic              w_sel   [2];
   logic [3:0]        w_op    [2];

   assign w_valid[0] = req0_valid;
   assign w_opr1[0]  = req0_opr1;
   assign w_opr2[0]  = req0_opr2;
   assign w_imm[0]   = req0_imm;
   assign w_sel[0]   = req0_selopr2;
   assign w_op[0]    = req0_aluoper;

   assign w_valid[1] = req1_valid;
   assign w_opr1[1]  = req1_opr1;
   assign w_opr2[1]  = req1_opr2;
   assign w_imm[1]   = req1_imm;
   assign w_sel[1]   = req1_selopr2;
   assign w_op[1]    = req1_aluoper;

   logic w_any_valid;
   logic w_grant;
   logic w_accept;

   // On a tie the requester that did not win last time goes first
   assign w_any_valid = w_valid[0] | w_valid[1];
   assign w_grant     = (w_valid[0] & w_valid[1]) ? ~r_last_grant : w_valid[1];
   assign w_accept    = (r_state == ST_IDLE) & w_any_valid & ~reset;

   assign req0_ready = w_accept & ~w_grant;
   assign req1_ready = w_accept &  w_grant;

   always_comb begin
      w_state_next      = r_state;
      w_cnt_next        = r_cnt;
      w_last_grant_next = r_last_grant;
      w_alu_opr1_next   = r_alu_opr1;
      w_alu_opr2_next   = r_alu_opr2;
      w_alu_imm_next    = r_alu_imm;
      w_alu_sel_next    = r_alu_sel;
      w_alu_op_next     = r_alu_op;
      w_rsp_id_next     = r_rsp_id;
      w_rsp_result_next = r_rsp_result;
      w_rsp_zero_next   = r_rsp_zero;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_alu_opr1_next   = w_opr1[w_grant];
               w_alu_opr2_next   = w_opr2[w_grant];
               w_alu_imm_next    = w_imm[w_grant];
               w_alu_sel_next    = w_sel[w_grant];
               w_alu_op_next     = w_op[w_grant];
               w_rsp_id_next     = w_grant;
               w_last_grant_next = w_grant;
               w_cnt_next        = LAT_INIT;
               w_state_next      = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (r_cnt != '0) begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end else begin
               w_rsp_result_next = alu_result;
               w_rsp_zero_next   = alu_zero;
               w_state_next      = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_last_grant <= 1'b1;
         r_alu_opr1   <= '0;
         r_alu_opr2   <= '0;
         r_alu_imm    <= '0;
         r_alu_sel    <= 1'b0;
         r_alu_op     <= '0;
         r_rsp_id     <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_zero   <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_last_grant <= w_last_grant_next;
         r_alu_opr1   <= w_alu_opr1_next;
         r_alu_opr2   <= w_alu_opr2_next;
         r_alu_imm    <= w_alu_imm_next;
         r_alu_sel    <= w_alu_sel_next;
         r_alu_op     <= w_alu_op_next;
         r_rsp_id     <= w_rsp_id_next;
         r_rsp_result <= w_rsp_result_next;
         r_rsp_zero   <= w_rsp_zero_next;
      end
   end

   assign alu_rdatain1  = r_alu_opr1;
   assign alu_rdatain2  = r_alu_opr2;
   assign alu_dataimmed = r_alu_imm;
   assign alu_selopr2   = r_alu_sel;
   assign alu_aluoper   = r_alu_op;

   assign rsp_valid  = (r_state == ST_RESP);
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign rsp_zero   = r_rsp_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a one-cycle registered ALU model attached
// to the alu_* drives.
module tb_alu_arbiter;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic          req0_ready, req1_ready;
   logic [DW-1:0] req0_opr1 = '0, req0_opr2 = '0, req0_imm = '0;
   logic [DW-1:0] req1_opr1 = '0, req1_opr2 = '0, req1_imm = '0;
   logic          req0_selopr2 = 1'b0, req1_selopr2 = 1'b0;
   logic [3:0]    req0_aluoper = '0, req1_aluoper = '0;
   logic [DW-1:0] alu_rdatain1, alu_rdatain2, alu_dataimmed;
   logic          alu_selopr2;
   logic [3:0]    alu_aluoper;
   logic [DW-1:0] alu_result;
   logic          alu_zero;
   logic          rsp_valid, rsp_id, rsp_zero;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_result;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   alu_arbiter #(.DATA_W(DW), .ALU_LAT(1)) dut (
      .clock(clk), .reset(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opr1(req0_opr1),
      .req0_opr2(req0_opr2), .req0_imm(req0_imm), .req0_selopr2(req0_selopr2),
      .req0_aluoper(req0_aluoper),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opr1(req1_opr1),
      .req1_opr2(req1_opr2), .req1_imm(req1_imm), .req1_selopr2(req1_selopr2),
      .req1_aluoper(req1_aluoper),
      .alu_rdatain1(alu_rdatain1), .alu_rdatain2(alu_rdatain2),
      .alu_dataimmed(alu_dataimmed), .alu_selopr2(alu_selopr2),
      .alu_aluoper(alu_aluoper), .alu_result(alu_result), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference ALU: result appears one cycle after the operands settle
   function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [3:0] op);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a << b[4:0];
         4'd6: return a >> b[4:0];
         4'd7: return $signed(a) >>> b[4:0];
         4'd8: return {31'b0, $signed(a) < $signed(b)};
         4'd9: return {31'b0, a < b};
         default: return '0;
      endcase
   endfunction

   logic [DW-1:0] alu_q = '0;
   always_ff @(posedge clk)
      alu_q <= alu_fn(alu_rdatain1, alu_selopr2 ? alu_dataimmed : alu_rdatain2, alu_aluoper);
   assign alu_result = alu_q;
   assign alu_zero   = (alu_q == '0);

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end else begin
         $display("ok   %s: %h (cycle %0d)", tag, got, cyc);
      end
   endtask

   task automatic set_req(input int idx, input logic v, input logic [DW-1:0] o1,
                          input logic [DW-1:0] o2, input logic [DW-1:0] im,
                          input logic sel, input logic [3:0] op);
      if (idx == 0) begin
         req0_valid = v; req0_opr1 = o1; req0_opr2 = o2; req0_imm = im;
         req0_selopr2 = sel; req0_aluoper = op;
      end else begin
         req1_valid = v; req1_opr1 = o1; req1_opr2 = o2; req1_imm = im;
         req1_selopr2 = sel; req1_aluoper = op;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Called in the drive phase; returns in the drive phase after the accept edge.
   task automatic wait_accept(input int idx, input string tag, output int t);
      int n;
      logic seen;
      n = 0; seen = 1'b0; t = -1;
      while (!seen && n < 20) begin
         @(negedge clk);
         if ((idx == 0) ? req0_ready : req1_ready) begin
            seen = 1'b1;
            t = cyc;
         end
         @(posedge clk); #1;
         n++;
      end
      check_val({tag, "_accepted"}, 64'(seen), 64'd1);
   endtask

   // Waits for rsp_valid, checks latency and payload, then consumes the handshake edge.
   task automatic collect_rsp(input int t_acc, input logic exp_id, input logic [DW-1:0] exp_res,
                              input logic exp_zero, input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val({tag, "_rsp_seen"}, 64'(rsp_valid), 64'd1);
      if (t_acc >= 0) check_val({tag, "_latency"}, 64'(cyc - t_acc), 64'd3);
      check_val({tag, "_rsp_id"}, 64'(rsp_id), 64'(exp_id));
      check_val({tag, "_rsp_result"}, 64'(rsp_result), 64'(exp_res));
      check_val({tag, "_rsp_zero"}, 64'(rsp_zero), 64'(exp_zero));
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int g_exp, n_grant, n_rsp, n0, n1, guard;
      logic seen;

      // Reset state
      do_reset();
      @(negedge clk);
      check_val("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check_val("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);
      check_val("rst_alu_opr1", 64'(alu_rdatain1), 64'd0);
      check_val("rst_rsp_result", 64'(rsp_result), 64'd0);
      @(posedge clk); #1;

      // 1: single ADD from req0
      rsp_ready = 1'b1;
      set_req(0, 1'b1, 32'h10, 32'h20, 32'h0, 1'b0, 4'd0);
      wait_accept(0, "t1", t);
      req0_valid = 1'b0;
      collect_rsp(t, 1'b0, 32'h30, 1'b0, "t1");
      @(negedge clk);
      check_val("t1_idle_after", 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;

      // 2: simultaneous requests after reset, req0 first
      do_reset();
      set_req(0, 1'b1, 32'h10, 32'h10, 32'h0, 1'b0, 4'd1);
      set_req(1, 1'b1, 32'h10, 32'h20, 32'h0, 1'b0, 4'd3);
      @(negedge clk);
      check_val("t2_tie_ready", 64'({req1_ready, req0_ready}), 64'b01);
      t = cyc;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      collect_rsp(t, 1'b0, 32'h0, 1'b1, "t2a");
      wait_accept(1, "t2b", t);
      req1_valid = 1'b0;
      collect_rsp(t, 1'b1, 32'h30, 1'b0, "t2b");

      // 3: both continuously valid, three ops each, strict alternation
      set_req(0, 1'b1, 32'h100, 32'h1, 32'h0, 1'b0, 4'd0);
      set_req(1, 1'b1, 32'h200, 32'h1, 32'h0, 1'b0, 4'd1);
      g_exp = 0; n_grant = 0; n_rsp = 0; n0 = 0; n1 = 0; guard = 0;
      while (n_rsp < 6 && guard < 80) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            check_val("t3_onehot", 64'(req0_ready & req1_ready), 64'd0);
            check_val("t3_grant", 64'(req1_ready), 64'(g_exp));
            if (req0_ready) n0++; else n1++;
            g_exp ^= 1;
            n_grant++;
         end
         if (rsp_valid) begin
            check_val("t3_rsp_id", 64'(rsp_id), 64'(n_rsp % 2));
            check_val("t3_rsp_result", 64'(rsp_result),
                      (n_rsp % 2 == 0) ? 64'h101 : 64'h1FF);
            n_rsp++;
         end
         @(posedge clk); #1;
         if (n0 == 3) req0_valid = 1'b0;
         if (n1 == 3) req1_valid = 1'b0;
         guard++;
      end
      check_val("t3_grant_count", 64'(n_grant), 64'd6);

      // 4: response back-pressure blocks new accepts
      rsp_ready = 1'b0;
      set_req(0, 1'b1, 32'h3, 32'h4, 32'h0, 1'b0, 4'd0);
      wait_accept(0, "t4a", t);
      set_req(0, 1'b1, 32'h77, 32'h1, 32'h0, 1'b0, 4'd0);
      set_req(1, 1'b1, 32'h9, 32'h4, 32'h0, 1'b0, 4'd1);
      guard = 0;
      @(negedge clk);
      while (!rsp_valid && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      for (int i = 0; i < 5; i++) begin
         check_val("t4_hold_valid", 64'(rsp_valid), 64'd1);
         check_val("t4_hold_result", 64'(rsp_result), 64'h7);
         check_val("t4_hold_id", 64'(rsp_id), 64'd0);
         check_val("t4_blocked", 64'({req0_ready, req1_ready}), 64'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check_val("t4_last_resp", 64'(rsp_valid), 64'd1);
      @(negedge clk);
      check_val("t4_next_accept", 64'({req1_ready, req0_ready}), 64'b10);
      t = cyc;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      collect_rsp(t, 1'b1, 32'h5, 1'b0, "t4b");

      // 5: immediate operand path (SLL, SRA), payload changes after accept ignored
      set_req(1, 1'b1, 32'h10, 32'hDEAD, 32'h2, 1'b1, 4'd5);
      wait_accept(1, "t5a", t);
      set_req(1, 1'b0, 32'hFFFF, 32'h1, 32'h7, 1'b0, 4'd0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_val("t5_alu_imm", 64'(alu_dataimmed), 64'h2);
         check_val("t5_alu_sel", 64'(alu_selopr2), 64'd1);
         check_val("t5_alu_opr1", 64'(alu_rdatain1), 64'h10);
         check_val("t5_alu_op", 64'(alu_aluoper), 64'd5);
         @(posedge clk); #1;
      end
      t = -1;
      collect_rsp(t, 1'b1, 32'h40, 1'b0, "t5a");
      set_req(1, 1'b1, 32'hF0000010, 32'h0, 32'h2, 1'b1, 4'd7);
      wait_accept(1, "t5b", t);
      req1_valid = 1'b0;
      collect_rsp(t, 1'b1, 32'hFC000004, 1'b0, "t5b");

      // 6: asynchronous reset in BUSY discards the operation
      set_req(0, 1'b1, 32'h1, 32'h2, 32'h5, 1'b1, 4'd3);
      wait_accept(0, "t6a", t);
      req0_valid = 1'b0;
      rst = 1'b1;
      #1;
      check_val("t6_async_alu_opr1", 64'(alu_rdatain1), 64'd0);
      check_val("t6_async_alu_opr2", 64'(alu_rdatain2), 64'd0);
      check_val("t6_async_alu_imm", 64'(alu_dataimmed), 64'd0);
      check_val("t6_async_alu_sel", 64'(alu_selopr2), 64'd0);
      check_val("t6_async_alu_op", 64'(alu_aluoper), 64'd0);
      check_val("t6_async_rsp", 64'({rsp_valid, rsp_id, rsp_zero}), 64'd0);
      check_val("t6_async_rsp_result", 64'(rsp_result), 64'd0);
      check_val("t6_async_ready", 64'({req0_ready, req1_ready}), 64'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check_val("t6_no_stale_rsp", 64'(seen), 64'd0);
      @(posedge clk); #1;
      set_req(1, 1'b1, 32'h5, 32'h6, 32'h0, 1'b0, 4'd0);
      wait_accept(1, "t6b", t);
      req1_valid = 1'b0;
      collect_rsp(t, 1'b1, 32'hB, 1'b0, "t6b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
